// File: rtl/quad_encoder_emu_if.sv
// Stimulus/observation bundle for the quadrature encoder emulator.
// master = the step-request source, slave = the emulator.
interface quad_encoder_emu_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
);
  logic             step_req_i;
  logic             step_dir_i;
  logic             abort_i;
  logic [DIV_W-1:0] period_i;
  logic             rot_1_o;
  logic             rot_2_o;
  logic             busy_o;
  logic [CNT_W-1:0] pending_o;
  logic             detent_o;
  logic             ovf_o;

  modport master (
    output step_req_i, step_dir_i, abort_i, period_i,
    input  rot_1_o, rot_2_o, busy_o, pending_o, detent_o, ovf_o
  );

  modport slave (
    input  step_req_i, step_dir_i, abort_i, period_i,
    output rot_1_o, rot_2_o, busy_o, pending_o, detent_o, ovf_o
  );
endinterface

// File: rtl/quad_encoder_emu.sv
// Quadrature rotary-encoder emulator: turns queued detent requests into A/B Gray waveforms.
// Optional QUAD_BOUNCE_EN: each A/B edge is emitted as new/old/new to exercise decoder debounce.
module quad_encoder_emu #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
) (
  input logic               CLK_i,
  input logic               RSTn_i,
  quad_encoder_emu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;

`ifdef QUAD_BOUNCE_EN
  localparam logic [DIV_W-1:0] D_MIN = DIV_W'(3);
`else
  localparam logic [DIV_W-1:0] D_MIN = DIV_W'(1);
`endif
  localparam logic [DIV_W-1:0]     ONE_D = DIV_W'(1);
  localparam logic signed [CNT_W:0] ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic signed [CNT_W:0] LIM  = {2'b00, {(CNT_W-1){1'b1}}};

  state_t                  state_q;
  logic [DIV_W-1:0]        dwell_q;
  logic [DIV_W-1:0]        dlat_q;
  logic                    cw_q;
  logic [1:0]              ab_q;
  logic                    busy_q;
  logic                    detent_q;
  logic                    ovf_q;
  logic signed [CNT_W-1:0] pend_q;

  logic [DIV_W-1:0]        d_eff;
  logic                    start;
  logic                    pend_pos;
  logic                    drop;
  logic signed [CNT_W:0]   pend_ext;
  logic signed [CNT_W:0]   base;
  logic signed [CNT_W:0]   cand;
  logic signed [CNT_W:0]   pend_nxt;

  // A/B levels {A,B} for each quarter; CW lets A fall first.
  function automatic logic [1:0] ab_of(input state_t s, input logic cw);
    case (s)
      Q1:      ab_of = cw ? 2'b01 : 2'b10;
      Q2:      ab_of = 2'b00;
      Q3:      ab_of = cw ? 2'b10 : 2'b01;
      default: ab_of = 2'b11;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      Q1:      next_of = Q2;
      Q2:      next_of = Q3;
      Q3:      next_of = Q4;
      default: next_of = IDLE;
    endcase
  endfunction

`ifdef QUAD_BOUNCE_EN
  // Level held before entering s; Q1 is always entered from the 11 detent.
  function automatic state_t prev_of(input state_t s);
    case (s)
      Q2:      prev_of = Q1;
      Q3:      prev_of = Q2;
      Q4:      prev_of = Q3;
      default: prev_of = Q4;
    endcase
  endfunction
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_eff    = (bus.period_i < D_MIN) ? D_MIN : bus.period_i;
    pend_ext = {pend_q[CNT_W-1], pend_q};
    pend_pos = !pend_q[CNT_W-1] && (pend_q != '0);
    start    = (pend_q != '0) &&
               ((state_q == IDLE) || ((state_q == Q4) && (dwell_q == '0)));
    base     = pend_ext;
    if (start) base = pend_pos ? pend_ext - ONE : pend_ext + ONE;
    cand     = bus.step_dir_i ? base + ONE : base - ONE;
    drop     = bus.step_req_i && ((cand > LIM) || (cand < -LIM));
    pend_nxt = base;
    if (bus.abort_i)                        pend_nxt = '0;
    else if (bus.step_req_i && !drop)       pend_nxt = cand;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt[CNT_W-1:0];
      // An abort swallows a same-cycle request silently.
      ovf_q  <= drop && !bus.abort_i;
    end
  end

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      dlat_q   <= '0;
      cw_q     <= 1'b0;
      ab_q     <= 2'b11;
      busy_q   <= 1'b0;
      detent_q <= 1'b0;
    end else begin
      detent_q <= 1'b0;
      if (start) begin
        // Fresh detent, either from IDLE or chained straight off the end of Q4.
        state_q  <= Q1;
        cw_q     <= pend_pos;
        dlat_q   <= d_eff;
        dwell_q  <= d_eff - ONE_D;
        ab_q     <= ab_of(Q1, pend_pos);
        busy_q   <= 1'b1;
        detent_q <= (state_q == Q4);
      end else if (state_q != IDLE) begin
        if (dwell_q == '0) begin
          if (state_q == Q4) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            detent_q <= 1'b1;
            ab_q     <= 2'b11;
          end else begin
            state_q <= next_of(state_q);
            dwell_q <= dlat_q - ONE_D;
            ab_q    <= ab_of(next_of(state_q), cw_q);
          end
        end else begin
          dwell_q <= dwell_q - ONE_D;
`ifdef QUAD_BOUNCE_EN
          // Second clock of each quarter briefly reverts to the previous level.
          ab_q <= (dwell_q == dlat_q - ONE_D) ? ab_of(prev_of(state_q), cw_q)
                                              : ab_of(state_q, cw_q);
`endif
        end
      end
    end
  end

  assign bus.rot_1_o   = ab_q[1];
  assign bus.rot_2_o   = ab_q[0];
  assign bus.busy_o    = busy_q;
  assign bus.pending_o = pend_q;
  assign bus.detent_o  = detent_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// Self-checking bench for quad_encoder_emu: directed scenarios plus random traffic
// compared every cycle against a timeline-based model of the quadrature output.
module tb_quad_encoder_emu;

  localparam int DIV_W = 16;
  localparam int CNT_W = 4;
  localparam int LIM   = 2 ** (CNT_W - 1) - 1;
`ifdef QUAD_BOUNCE_EN
  localparam int D_MIN  = 3;
  localparam bit BOUNCE = 1'b1;
`else
  localparam int D_MIN  = 1;
  localparam bit BOUNCE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  quad_encoder_emu_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  quad_encoder_emu #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .CLK_i  (clk),
    .RSTn_i (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model: a detent is a timeline of 4*D clocks; output is looked up from elapsed time.
  typedef struct {
    int pend;
    bit active;
    int el;
    int d;
    bit dir;
    bit det;
    bit ovf;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pend = 0; r.active = 1'b0; r.el = 0; r.d = 0;
    r.dir = 1'b0; r.det = 1'b0; r.ovf = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic req, logic dir, logic ab, int per);
    model_t n;
    int p;
    int q;
    n = c; n.det = 1'b0; n.ovf = 1'b0;
    p = c.pend;
    if (c.active) begin
      n.el = c.el + 1;
      if (n.el == 4 * c.d) begin
        n.det = 1'b1;
        n.active = 1'b0;
      end
    end
    if (!n.active && c.pend != 0) begin
      n.active = 1'b1;
      n.el = 0;
      n.dir = (c.pend > 0);
      n.d = (per < D_MIN) ? D_MIN : per;
      p = (c.pend > 0) ? c.pend - 1 : c.pend + 1;
    end
    if (ab) p = 0;
    else if (req) begin
      q = dir ? p + 1 : p - 1;
      if (q > LIM || q < -LIM) n.ovf = 1'b1;
      else p = q;
    end
    n.pend = p;
    return n;
  endfunction

  function automatic logic [1:0] model_ab(model_t c);
    logic [1:0] seq [4];
    int q;
    if (!c.active) return 2'b11;
    if (c.dir) seq = '{2'b01, 2'b00, 2'b10, 2'b11};
    else       seq = '{2'b10, 2'b00, 2'b01, 2'b11};
    q = c.el / c.d;
    if (BOUNCE && (c.el % c.d) == 1) q = (q + 3) % 4;
    return seq[q];
  endfunction

  function automatic logic [31:0] model_vec(model_t c);
    return 32'({model_ab(c), c.active, c.det, c.ovf, CNT_W'(c.pend)});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({bus.rot_1_o, bus.rot_2_o, bus.busy_o, bus.detent_o, bus.ovf_o, bus.pending_o});
  endfunction

  function automatic int pend_int();
    return int'($signed(bus.pending_o));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, bus.step_req_i, bus.step_dir_i, bus.abort_i, int'(bus.period_i));
  end

  always @(negedge clk) begin
    if (rst_n) check("cycle_vs_model", dut_vec(), model_vec(m));
  end

  // One call = inputs held across exactly one rising edge; returns at the following falling edge.
  task automatic drive(input logic req, input logic dir, input logic ab);
    bus.step_req_i = req;
    bus.step_dir_i = dir;
    bus.abort_i    = ab;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit, output int dets);
    int n;
    n = 0;
    dets = 0;
    while (bus.busy_o && n < limit) begin
      drive(1'b0, 1'b0, 1'b0);
      n++;
      if (bus.detent_o) dets++;
    end
    check("wait_idle_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dets, busy_cnt, min_p, ovf_cnt;
    logic [1:0] exp_ab;

    bus.step_req_i = 1'b0;
    bus.step_dir_i = 1'b0;
    bus.abort_i    = 1'b0;
    bus.period_i   = 16'd3;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 32'({2'b11, 1'b0, 1'b0, 1'b0, 4'h0}));
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single CW detent, period 3: 01/00/10/11 each 3 clocks, detent at edge 13.
    drive(1'b1, 1'b1, 1'b0);
    check("t1_pend_after_req", 32'(pend_int()), 32'd1);
    check("t1_ab_edge0", 32'({bus.rot_1_o, bus.rot_2_o}), 32'b11);
    for (int e = 1; e <= 14; e++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_ab = (e <= 3) ? 2'b01 : (e <= 6) ? 2'b00 : (e <= 9) ? 2'b10 : 2'b11;
      if (e == 1 || e == 4 || e == 7 || e == 10)
        check($sformatf("t1_ab_edge%0d", e), 32'({bus.rot_1_o, bus.rot_2_o}), 32'(exp_ab));
      if (e == 1)  check("t1_pend_consumed", 32'(pend_int()), 32'd0);
      if (e == 12) check("t1_busy_q4", 32'(bus.busy_o), 32'd1);
      if (e == 13) check("t1_detent_edge13", 32'({bus.detent_o, bus.busy_o}), 32'b10);
      if (e == 14) check("t1_detent_cleared", 32'(bus.detent_o), 32'd0);
    end

    // Three CCW requests, period 2: back-to-back B-leading detents.
    bus.period_i = 16'd2;
    busy_cnt = 0; dets = 0; min_p = 0;
    for (int i = 0; i < 50; i++) begin
      drive(i < 3, 1'b0, 1'b0);
      if (i == 1) check("t2_ab_ccw_q1", 32'({bus.rot_1_o, bus.rot_2_o}), 32'b10);
      if (bus.busy_o) busy_cnt++;
      if (bus.detent_o) dets++;
      if (pend_int() < min_p) min_p = pend_int();
    end
    check("t2_min_pending", 32'(min_p), 32'(-2));
    check("t2_busy_clocks", 32'(busy_cnt), 32'(12 * ((D_MIN > 2) ? D_MIN : 2)));
    check("t2_detents", 32'(dets), 32'd3);

    // Ten CW requests at period 100: saturate at 7, two drops.
    bus.period_i = 16'd100;
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (bus.ovf_o) ovf_cnt++;
    end
    check("t3_pend_sat", 32'(pend_int()), 32'd7);
    check("t3_ovf_count", 32'(ovf_cnt), 32'd2);
    drive(1'b0, 1'b0, 1'b1);
    check("t3_abort_pend", 32'(pend_int()), 32'd0);
    wait_idle(500, dets);
    check("t3_one_detent", 32'(dets), 32'd1);

    // CW then CCW during a detent cancel out.
    bus.period_i = 16'd4;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t4_pend_plus", 32'(pend_int()), 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    check("t4_pend_zero", 32'(pend_int()), 32'd0);
    wait_idle(100, dets);
    check("t4_one_detent", 32'(dets), 32'd1);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("t4_stays_idle", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset in the middle of Q2.
    bus.period_i = 16'd3;
    drive(1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("t5_mid_q2", 32'({bus.rot_1_o, bus.rot_2_o}), 32'b00);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", dut_vec(), 32'({2'b11, 1'b0, 1'b0, 1'b0, 4'h0}));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("t5_idle_after", 32'({bus.rot_1_o, bus.rot_2_o, bus.busy_o}), 32'b110);

    // Abort with a simultaneous request while 5 steps are queued mid-Q2.
    bus.period_i = 16'd4;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(i >= 1, 1'b1, 1'b0);
    check("t6_pend5", 32'(pend_int()), 32'd5);
    check("t6_in_q2", 32'({bus.rot_1_o, bus.rot_2_o}), 32'b00);
    drive(1'b1, 1'b1, 1'b1);
    check("t6_abort_pend", 32'(pend_int()), 32'd0);
    check("t6_no_ovf", 32'(bus.ovf_o), 32'd0);
    wait_idle(100, dets);
    check("t6_detent_done", 32'(dets), 32'd1);

`ifdef QUAD_BOUNCE_EN
    // Period 1 is stretched to 3; each quarter shows new/old/new.
    bus.period_i = 16'd1;
    drive(1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_ab = (e == 1 || e == 3) ? 2'b01 : (e == 2) ? 2'b11 : (e == 5) ? 2'b01 : 2'b00;
      check($sformatf("bounce_edge%0d", e), 32'({bus.rot_1_o, bus.rot_2_o}), 32'(exp_ab));
    end
    wait_idle(100, dets);
`endif

    // Random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) bus.period_i = 16'($urandom_range(0, 4));
      drive($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 2);
    end
    drive(1'b0, 1'b0, 1'b1);
    wait_idle(100, dets);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
